// File: rtl/mod_exponent.sv
// mod_exponent: constant-time Montgomery modular exponentiation, c = b^e mod N.
// Base arrives in Montgomery form; the result leaves in normal form.
module mod_exponent #(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulo,
  input  logic [WIDTH-1:0] inv_modulo,
  input  logic [WIDTH:0]   R,
  input  logic [WIDTH-1:0] start_product,
  input  logic             valid_in,
  output logic [WIDTH-1:0] c_out,
  output logic             valid_out,
  output logic             busy_out
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, SQUARE, MULT, CONVERT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [IW-1:0] i_q, i_d;
  logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, n_q, n_d, np_q, np_d;
  logic [WIDTH-1:0] acc_q, acc_d, m_q, m_d, c_q, c_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0] u_q, u_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic [WIDTH-1:0] y, res;
  logic [2*WIDTH-1:0] mn;
  logic unused_r;
  assign unused_r = ^R;
  // Second multiplicand: acc when squaring, base when multiplying, 1 to leave Montgomery form
  assign y = (state_q == SQUARE) ? acc_q : (state_q == MULT) ? base_q : WIDTH'(1);
  assign mn = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, n_q};
  assign res = (u_q >= {1'b0, n_q}) ? WIDTH'(u_q - {1'b0, n_q}) : u_q[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    i_d     = i_q;
    base_d  = base_q;
    exp_d   = exp_q;
    n_d     = n_q;
    np_d    = np_q;
    acc_d   = acc_q;
    m_d     = m_q;
    c_d     = c_q;
    prod_d  = prod_q;
    u_d     = u_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (valid_in) begin
        base_d  = base;
        exp_d   = exponent;
        n_d     = modulo;
        np_d    = inv_modulo;
        acc_d   = start_product;
        i_d     = IW'(WIDTH - 1);
        ph_d    = 2'd0;
        busy_d  = 1'b1;
        state_d = SQUARE;
      end
      SQUARE, MULT, CONVERT: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd0) prod_d = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, y};
        if (ph_q == 2'd1) m_d = prod_q[WIDTH-1:0] * np_q;
        if (ph_q == 2'd2) u_d = (WIDTH+1)'(({1'b0, prod_q} + {1'b0, mn}) >> WIDTH);
        if (ph_q == 2'd3) begin
          // MULT always computes; only the exponent bit decides whether the product is kept
          acc_d   = (state_q != MULT || exp_q[i_q]) ? res : acc_q;
          state_d = (state_q == SQUARE) ? MULT : (state_q == CONVERT) ? DONE :
                    (i_q == '0) ? CONVERT : SQUARE;
          if (state_q == MULT && i_q != '0) i_d = i_q - IW'(1);
        end
      end
      DONE: begin
        c_d     = acc_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ph_q    <= '0;
      i_q     <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      np_q    <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      c_q     <= '0;
      prod_q  <= '0;
      u_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      i_q     <= i_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      np_q    <= np_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      c_q     <= c_d;
      prod_q  <= prod_d;
      u_q     <= u_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end
  assign c_out     = c_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
endmodule

// File: tb/tb_mod_exponent.sv
// tb_mod_exponent: scoreboard bench for mod_exponent at WIDTH=8 and WIDTH=512.
// Expected results come from plain repeated modular multiplication.
module tb_mod_exponent;
  localparam int SW = 8, BW = 512, SLAT = 69, BLAT = 4101;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_s, rst_b;
  logic [SW-1:0] s_base, s_exp, s_n, s_np, s_sp, s_c;
  logic [SW:0] s_r;
  logic s_vin, s_vout, s_busy;
  logic [BW-1:0] b_base, b_exp, b_n, b_np, b_sp, b_c;
  logic [BW:0] b_r;
  logic b_vin, b_vout, b_busy;
  mod_exponent #(.WIDTH(SW)) dut_s (
    .clk_in(clk), .rst_in(rst_s), .base(s_base), .exponent(s_exp), .modulo(s_n),
    .inv_modulo(s_np), .R(s_r), .start_product(s_sp), .valid_in(s_vin),
    .c_out(s_c), .valid_out(s_vout), .busy_out(s_busy));
  mod_exponent #(.WIDTH(BW)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .base(b_base), .exponent(b_exp), .modulo(b_n),
    .inv_modulo(b_np), .R(b_r), .start_product(b_sp), .valid_in(b_vin),
    .c_out(b_c), .valid_out(b_vout), .busy_out(b_busy));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  typedef struct {logic [SW-1:0] c; int t;} sexp_t;
  sexp_t sq[$];
  logic [BW-1:0] bq_c[$];
  int bq_t[$];

  task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [SW-1:0] ref8(int b, int e, int n);
    longint r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * b) % n;
    return SW'(r);
  endfunction

  function automatic logic [SW-1:0] np8(int n);
    for (int x = 0; x < 256; x++) if (((n * x) & 255) == 255) return SW'(x);
    return '0;
  endfunction

  function automatic logic [BW-1:0] rnd512();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] bmodexp(logic [BW-1:0] b, logic [BW-1:0] e, logic [BW-1:0] n);
    logic [2*BW-1:0] r, bb, nn;
    r = 1;
    bb = {{BW{1'b0}}, b};
    nn = {{BW{1'b0}}, n};
    for (int k = BW - 1; k >= 0; k--) begin
      r = (r * r) % nn;
      if (e[k]) r = (r * bb) % nn;
    end
    return r[BW-1:0];
  endfunction

  always @(negedge clk) begin
    sexp_t e;
    if (rst_s && s_vout) begin
      if (sq.size() == 0) flag("small_unexpected_valid");
      else begin
        e = sq.pop_front();
        chk("small_c", s_c, e.c);
        chk("small_latency", cyc - e.t, SLAT);
        chk("small_busy_at_valid", s_busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b && b_vout) begin
      if (bq_c.size() == 0) flag("big_unexpected_valid");
      else begin
        chk("big_c", b_c, bq_c.pop_front());
        chk("big_latency", cyc - bq_t.pop_front(), BLAT);
      end
    end
  end

  // Called right after a negedge; returns at the negedge following the accepting edge
  task automatic s_send(int n, int bplain, int e, bit accept);
    sexp_t x;
    s_n = SW'(n);
    s_np = np8(n);
    s_sp = SW'(256 % n);
    s_base = SW'((bplain * 256) % n);
    s_exp = SW'(e);
    s_vin = 1'b1;
    if (accept) begin
      x.c = ref8(bplain % n, e, n);
      x.t = cyc + 1;
      sq.push_back(x);
    end
    @(negedge clk);
    s_vin = 1'b0;
    if (accept) chk("small_busy_after_accept", s_busy, 1);
  endtask

  task automatic s_wait_vout();
    for (int k = 0; k < 200 && !s_vout; k++) @(negedge clk);
    if (!s_vout) begin
      flag("small_valid_timeout");
      sq.delete();
    end
  endtask

  task automatic s_wait_idle();
    for (int k = 0; k < 200 && sq.size() != 0; k++) @(negedge clk);
    if (sq.size() != 0) begin
      flag("small_idle_timeout");
      sq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [BW-1:0] bn, bb, be, x;
    logic [2*BW-1:0] rr;
    rst_s = 1'b0;
    rst_b = 1'b0;
    s_vin = 1'b0;
    b_vin = 1'b0;
    {s_base, s_exp, s_n, s_np, s_sp} = '0;
    {b_base, b_exp, b_n, b_np, b_sp} = '0;
    s_r = 9'd256;
    b_r = {1'b1, {BW{1'b0}}};
    repeat (2) @(negedge clk);
    chk("reset_c", s_c, 0);
    chk("reset_valid", s_vout, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_big_c", b_c, 0);
    rst_s = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    bn = rnd512() | 1 | ({BW{1'b0}} | (1 << (BW - 1)));
    bb = rnd512() % bn;
    be = rnd512();
    x = 1;
    repeat (10) x = x * (BW'(2) - bn * x);
    b_np = BW'(0) - x;
    rr = {{(BW-1){1'b0}}, 1'b1, {BW{1'b0}}};
    b_sp = BW'(rr % {{BW{1'b0}}, bn});
    b_base = BW'({bb, {BW{1'b0}}} % {{BW{1'b0}}, bn});
    b_n = bn;
    b_exp = be;
    b_vin = 1'b1;
    bq_c.push_back(bmodexp(bb, be, bn));
    bq_t.push_back(cyc + 1);
    @(negedge clk);
    b_vin = 1'b0;
    chk("big_busy_after_accept", b_busy, 1);
    s_send(61, 69, 8, 1);
    s_wait_vout();
    s_send(61, 69, 0, 1);
    s_wait_vout();
    s_send(61, 69, 255, 1);
    s_wait_idle();
    s_send(61, 0, 5, 1);
    s_wait_idle();
    s_send(61, 69, 8, 1);
    repeat (10) @(negedge clk);
    s_send(97, 5, 3, 0);
    s_wait_idle();
    repeat (80) @(negedge clk);
    s_send(61, 69, 255, 1);
    repeat (20) @(negedge clk);
    rst_s = 1'b0;
    sq.delete();
    @(negedge clk);
    chk("midreset_c", s_c, 0);
    chk("midreset_valid", s_vout, 0);
    chk("midreset_busy", s_busy, 0);
    rst_s = 1'b1;
    repeat (80) @(negedge clk);
    s_send(61, 69, 8, 1);
    for (int j = 0; j < 10; j++) begin
      s_wait_vout();
      if (j % 2 == 1) begin
        @(negedge clk);
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      s_send(int'($urandom_range(3, 255) | 1), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 1);
    end
    s_wait_idle();
    chk("big_busy_midrun", b_busy, 1);
    for (int k = 0; k < 6000 && bq_c.size() != 0; k++) @(negedge clk);
    if (bq_c.size() != 0) flag("big_valid_timeout");
    repeat (3) @(negedge clk);
    chk("big_busy_after_done", b_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
